// File: rtl/data_ram_lsu_if.sv
// Request/response bundle between the execute stage and the load/store data RAM.
interface data_ram_lsu_if;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [31:0] offset;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output start, is_store, funct3, base, offset, wdata,
    input  busy, done, err, rdata
  );

  modport slave (
    input  start, is_store, funct3, base, offset, wdata,
    output busy, done, err, rdata
  );
endinterface

// File: rtl/data_ram_lsu.sv
// Load/store unit with an internal word-wide byte-enabled synchronous RAM.
// Handles RISC-V B/H/W/BU/HU loads and B/H/W stores; word-crossing accesses
// are split into two beats (MISALIGN_EN=1) or rejected (MISALIGN_EN=0).
module data_ram_lsu #(
  parameter int ADDR_W      = 10,
  parameter bit MISALIGN_EN = 1'b1
) (
  input logic           clk,
  input logic           rst,
  data_ram_lsu_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_t;

  // Access size in bytes from funct3[1:0].
  function automatic logic [2:0] size_of(input logic [1:0] f3lo);
    case (f3lo)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // True when the access runs past the end of its word.
  function automatic logic spans(input logic [1:0] off, input logic [2:0] sz);
    return ({2'b00, off} + {1'b0, sz}) > 4'd4;
  endfunction

  // Sign- or zero-extend the low bytes of a load result.
  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b100:  return {24'b0, v[7:0]};
      3'b101:  return {16'b0, v[15:0]};
      default: return v;
    endcase
  endfunction

  state_t state_q, state_d;

  logic [ADDR_W+1:0] ea_q, ea_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              is_store_q, is_store_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       lo_q, lo_d;
  logic              err_pend_q, err_pend_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       ram_dout;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wd;
  logic [3:0]        ram_be;
  logic              ram_we;
  logic              ram_re;

  // Request decode on the live inputs, used only at acceptance.
  logic [31:0] ea_in;
  logic [2:0]  sz_in;
  logic        req_err;
  logic        accept;

  assign ea_in  = bus.base + bus.offset;
  assign sz_in  = size_of(bus.funct3[1:0]);
  assign accept = (state_q == IDLE) && bus.start;

  // Any decode fault sends the request straight to the response state.
  always_comb begin
    req_err = 1'b0;
    if (bus.funct3 == 3'b011 || bus.funct3 == 3'b110 || bus.funct3 == 3'b111)
      req_err = 1'b1;
    if (bus.is_store && bus.funct3[2])
      req_err = 1'b1;
    if (|(ea_in >> (ADDR_W + 2)))
      req_err = 1'b1;
    if (spans(ea_in[1:0], sz_in) && (ea_in[ADDR_W+1:2] == '1))
      req_err = 1'b1;
    if (!MISALIGN_EN && ((sz_in == 3'd2 && ea_in[0]) || (sz_in == 3'd4 && ea_in[1:0] != 2'b00)))
      req_err = 1'b1;
  end

  // Fields of the latched request.
  logic [2:0]        sz_q;
  logic [1:0]        off_q;
  logic              span_q;
  logic [ADDR_W-1:0] w0_q;
  logic [ADDR_W-1:0] w1_q;
  logic [63:0]       st_data;
  logic [7:0]        st_mask;
  logic [3:0]        be_base;
  logic [63:0]       ld_win;
  logic [63:0]       ld_sh;

  assign sz_q    = size_of(funct3_q[1:0]);
  assign off_q   = ea_q[1:0];
  assign span_q  = spans(off_q, sz_q);
  assign w0_q    = ea_q[ADDR_W+1:2];
  assign w1_q    = w0_q + ADDR_W'(1);
  assign be_base = (sz_q == 3'd1) ? 4'b0001 : (sz_q == 3'd2) ? 4'b0011 : 4'b1111;
  assign st_data = {32'b0, wdata_q} << {off_q, 3'b000};
  assign st_mask = {4'b0000, be_base} << off_q;
  assign ld_win  = span_q ? {ram_dout, lo_q} : {32'b0, ram_dout};
  assign ld_sh   = ld_win >> {off_q, 3'b000};

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = req_err ? RESP : ACC0;
      ACC0:    state_d = span_q ? ACC1 : RESP;
      ACC1:    state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: RAM port control for each access beat.
  always_comb begin
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = w0_q;
    ram_wd   = st_data[31:0];
    ram_be   = st_mask[3:0];
    case (state_q)
      ACC0: begin
        ram_we = is_store_q && rst;
        ram_re = !is_store_q;
      end
      ACC1: begin
        ram_addr = w1_q;
        ram_wd   = st_data[63:32];
        ram_be   = st_mask[7:4];
        ram_we   = is_store_q && rst;
        ram_re   = !is_store_q;
      end
      default: ;
    endcase
  end

  // Synchronous RAM: one-cycle read latency, per-byte write enables; never cleared.
  always_ff @(posedge clk) begin
    if (ram_re) ram_dout <= mem[ram_addr];
    for (int b = 0; b < 4; b++)
      if (ram_we && ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wd[8*b +: 8];
  end

  // Request latch and low-word capture for two-beat loads.
  always_comb begin
    ea_d       = ea_q;
    funct3_d   = funct3_q;
    is_store_d = is_store_q;
    wdata_d    = wdata_q;
    lo_d       = lo_q;
    if (accept) begin
      ea_d       = ea_in[ADDR_W+1:0];
      funct3_d   = bus.funct3;
      is_store_d = bus.is_store;
      wdata_d    = bus.wdata;
    end
    if (state_q == ACC1) lo_d = ram_dout;
  end

  // Datapath registers carry no reset.
  always_ff @(posedge clk) begin
    ea_q       <= ea_d;
    funct3_q   <= funct3_d;
    is_store_q <= is_store_d;
    wdata_q    <= wdata_d;
    lo_q       <= lo_d;
  end

  // Completion: done pulse, error flag and load result registered out of RESP.
  always_comb begin
    err_pend_d = err_pend_q;
    done_d     = (state_q == RESP);
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    if (accept) err_pend_d = req_err;
    if (state_q == RESP) begin
      err_d = err_pend_q;
      if (err_pend_q)       rdata_d = 32'b0;
      else if (!is_store_q) rdata_d = extend(ld_sh[31:0], funct3_q);
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_pend_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'b0;
    end else begin
      err_pend_q <= err_pend_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule
